// File: rtl/m107_palette_mixer.sv
// Palette mixer: tile/sprite priority merge, palette lookup, RGB expansion with matched timing delay.
// Define PAL_READBACK_EN to allow CPU reads of palette RAM (otherwise port B is write-only).
//
// CPU access FSM
//   state | meaning
//   IDLE  | waiting for a rising edge of pal_cs & (cpu_rd | cpu_wr)
//   REQ   | write lands in RAM, or read address presented to port B
//   RD    | port B data captured into cpu_dout
//   DONE  | last busy cycle before returning to IDLE
module m107_palette_mixer #(
    parameter int PIPE_DEPTH = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [10:0] tile_color,
    input  logic        tile_prio,
    input  logic [10:0] obj_color,
    input  logic        obj_prio,
    input  logic        color_blank_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pal_cs,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [10:0] addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        busy,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);

    if (PIPE_DEPTH != 3) begin : g_depth_check
        $error("m107_palette_mixer: only PIPE_DEPTH = 3 is supported");
    end

    typedef enum logic [1:0] {IDLE, REQ, RD, DONE} cpu_state_t;

    cpu_state_t  state;
    cpu_state_t  state_nxt;
    logic        req_now;
    logic        req_prev;
    logic        req_edge;
    logic        latch_en;
    logic        ram_we;
    logic [10:0] addr_q;
    logic [15:0] din_q;
    logic        we_q;

    logic [15:0] pal_ram [0:2047];
    logic [14:0] pal_a_q;

    logic        obj_opaque;
    logic        obj_wins;
    logic [10:0] mix_index;

    logic [10:0] s1_index;
    logic        s1_blank;
    logic        s1_hblank;
    logic        s1_vblank;
    logic        s1_hsync;
    logic        s1_vsync;
    logic        s2_blank;
    logic        s2_hblank;
    logic        s2_vblank;
    logic        s2_hsync;
    logic        s2_vsync;

    assign obj_opaque = |obj_color[3:0];
    assign obj_wins   = obj_opaque & (obj_prio | ~tile_prio);
    assign mix_index  = obj_wins ? obj_color : tile_color;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_index  <= '0;
            s1_blank  <= 1'b1;
            s1_hblank <= 1'b1;
            s1_vblank <= 1'b1;
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            s2_blank  <= 1'b1;
            s2_hblank <= 1'b1;
            s2_vblank <= 1'b1;
            s2_hsync  <= 1'b0;
            s2_vsync  <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end else if (ce_pix) begin
            s1_index  <= mix_index;
            s1_blank  <= color_blank_in;
            s1_hblank <= hblank_in;
            s1_vblank <= vblank_in;
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            s2_blank  <= s1_blank;
            s2_hblank <= s1_hblank;
            s2_vblank <= s1_vblank;
            s2_hsync  <= s1_hsync;
            s2_vsync  <= s1_vsync;
            // 5-bit channels widen by replicating their top bits so 31 maps to 255
            red       <= s2_blank ? 8'h00 : {pal_a_q[4:0],   pal_a_q[4:2]};
            green     <= s2_blank ? 8'h00 : {pal_a_q[9:5],   pal_a_q[9:7]};
            blue      <= s2_blank ? 8'h00 : {pal_a_q[14:10], pal_a_q[14:12]};
            hblank    <= s2_hblank;
            vblank    <= s2_vblank;
            hsync     <= s2_hsync;
            vsync     <= s2_vsync;
        end
    end

    // Video port sees pre-write contents on a same-address collision
    always_ff @(posedge clk) begin
        if (ce_pix) begin
            pal_a_q <= pal_ram[s1_index][14:0];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            pal_ram[addr_q] <= din_q;
        end
    end

    assign req_now  = pal_cs & (cpu_rd | cpu_wr);
    assign req_edge = req_now & ~req_prev;
    assign busy     = (state != IDLE);

`ifdef PAL_READBACK_EN
    logic        port_b_rd;
    logic        dout_load;
    logic [15:0] pal_b_q;
`endif

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        ram_we    = 1'b0;
`ifdef PAL_READBACK_EN
        port_b_rd = 1'b0;
        dout_load = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_edge) begin
                    latch_en = 1'b1;
`ifdef PAL_READBACK_EN
                    state_nxt = REQ;
`else
                    state_nxt = cpu_wr ? REQ : DONE;
`endif
                end
            end
            REQ: begin
                if (we_q) begin
                    ram_we    = 1'b1;
                    state_nxt = DONE;
                end else begin
`ifdef PAL_READBACK_EN
                    port_b_rd = 1'b1;
`endif
                    state_nxt = RD;
                end
            end
            RD: begin
`ifdef PAL_READBACK_EN
                dout_load = 1'b1;
`endif
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            req_prev <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_prev <= req_now;
            if (latch_en) begin
                addr_q <= addr;
                din_q  <= cpu_din;
                we_q   <= cpu_wr;
            end
        end
    end

`ifdef PAL_READBACK_EN
    always_ff @(posedge clk) begin
        if (port_b_rd) begin
            pal_b_q <= pal_ram[addr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_dout <= '0;
        end else if (dout_load) begin
            cpu_dout <= pal_b_q;
        end
    end
`else
    assign cpu_dout = '0;
`endif

endmodule
